// File: rtl/tl_stream_fifo.sv
// First-word-fall-through elastic buffer for TL streams, with registered
// occupancy, watermarks, synchronous flush and a peak-occupancy monitor.
module tl_stream_fifo #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_THRESH = DEPTH - 4,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     peak_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Elaboration stops on an illegal configuration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "tl_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $fatal(1, "tl_stream_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "tl_stream_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]     count_q, count_d;
  logic [PW-1:0]     peak_q, peak_d;
  logic              empty, full, wr_en, rd_en;

  // The extra pointer MSB tells a full lap from an empty queue.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_ready_o = !full && !flush_i;
  assign rd_valid_o = !empty && !flush_i;
  assign rd_data_o  = mem[rd_ptr_q[AW-1:0]];

  assign wr_en = wr_valid_i && wr_ready_o;
  assign rd_en = rd_valid_o && rd_ready_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (wr_en && !rd_en) begin
      count_d = count_q + PW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - PW'(1);
    end
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign count_o        = count_q;
  assign peak_o         = peak_q;
  assign almost_full_o  = (count_q >= AF_LVL);
  assign almost_empty_o = (count_q <= AE_LVL);

endmodule

// File: doc/tl_stream_fifo.md
# tl_stream_fifo

Parametrised synchronous first-word-fall-through FIFO for transaction-layer streams, generalised in data width and depth. Compared with the earlier stream FIFO it adds:
- a registered fill count and almost-full/almost-empty watermarks;
- a synchronous flush;
- a peak-occupancy monitor;
- `rd_valid_o` that never depends on `rd_ready_i`.

It sits between TL producers (TLP assembler, DLL retry path) and consumers as the standard elastic buffer.

## Interface
- `DATA_W`, 128: payload width in bits; carries packed `tl_pkg::tl_stream_t` or any other payload.
- `DEPTH`, 32: number of entries; power of two, ≥ 2.
- `AF_THRESH`, `DEPTH-4`: `almost_full_o` asserts when count ≥ `AF_THRESH`; range 1..`DEPTH`.
- `AE_THRESH`, 4: `almost_empty_o` asserts when count ≤ `AE_THRESH`; range 0..`DEPTH-1`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous flush; discards all contents.
- `wr_data_i`  in  `DATA_W`  write payload.
- `wr_valid_i`  in  1  write request.
- `wr_ready_o`  out  1  FIFO can accept a write this cycle.
- `rd_data_o`  out  `DATA_W`  head-of-queue payload.
- `rd_valid_o`  out  1  head entry valid.
- `rd_ready_i`  in  1  consumer accepts the head entry.
- `count_o`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `almost_full_o`  out  1  watermark flag.
- `almost_empty_o`  out  1  watermark flag.
- `peak_o`  out  `$clog2(DEPTH)+1`  highest occupancy since reset.

## Operation
- **Storage and pointers.** Storage is `DEPTH` × `DATA_W`, not reset. Read and write pointers are `$clog2(DEPTH)+1` bits wide; the MSB distinguishes full from empty. Addresses are the low `$clog2(DEPTH)` bits and wrap naturally at `DEPTH`.
- **Empty / full.** Empty when the pointers are equal. Full when the MSBs differ and the addresses are equal.
- **Handshakes.**
  - Write accepted iff `wr_valid_i && wr_ready_o`.
  - Read accepted iff `rd_valid_o && rd_ready_i`.
  - `wr_ready_o = !full && !flush_i`.
  - `rd_valid_o = !empty && !flush_i`. It must not depend on `rd_ready_i`.
  - `rd_data_o = mem[rd_addr]` combinationally (FWFT). The value is don't-care when `rd_valid_o` = 0.
- **Count.** `count_o` is a registered counter:
  - +1 on write only;
  - −1 on read only;
  - unchanged on simultaneous write+read or neither.
  - It must always equal `wr_ptr - rd_ptr`.
- **Flags.** Combinational from the `count_o` register: `almost_full_o = (count_o >= AF_THRESH)`, `almost_empty_o = (count_o <= AE_THRESH)`.
- **Peak.** `peak_o` is a registered maximum of the next-cycle count. It updates the same edge the count rises above it. It is not cleared by flush; only reset clears it.
- **Flush** (`flush_i` = 1 at an edge):
  - both pointers and `count_o` go to 0;
  - any write or read presented that cycle is refused, because the ready/valid outputs are forced low;
  - the FIFO is empty from the following cycle.
- **Boundary conditions.**
  - Full: a write is refused. A simultaneous read still completes and `count_o` drops to `DEPTH-1`. Full-cycle pass-through writes are not supported.
  - Empty: a write is accepted. `rd_valid_o` stays 0 this cycle, because there is no bypass.
  - Simultaneous write+read at any non-empty, non-full level leaves count unchanged and advances both pointers.
  - Pointer wrap past `2*DEPTH` is a modulo wrap with no special handling.
- **Reset.** Asynchronous reset at any time, including mid-transfer, returns the block to the reset state immediately. In-flight data is lost.
- **Parameter checks.** Illegal parameters (non-power-of-two `DEPTH`, thresholds out of range) must fail elaboration via an initial assertion.

## Timing
- **Reset values:**
  - `wr_ready_o` = 1 (unless `flush_i` = 1);
  - `rd_valid_o` = 0;
  - `count_o` = 0;
  - `peak_o` = 0;
  - `almost_full_o` = 0;
  - `almost_empty_o` = 1;
  - `rd_data_o` undefined.
- **Write-to-read latency:** 1 cycle. Data written at edge N is visible on `rd_data_o` with `rd_valid_o` = 1 after edge N.
- **Read-to-next-head latency:** 0 cycles. After the accepting edge the next entry is presented in the same following cycle.
- **Steady-state throughput:** one write and one read per cycle.
- **Update timing.** `count_o`, `peak_o` and the flags update at the edge of the handshake and are valid in the following cycle.
- **Backpressure.** `wr_ready_o` deasserts in the cycle after the write that fills the FIFO. It reasserts in the cycle after the first read from full.

## Test plan
- **Fill and drain.** With `DEPTH` = 8, write 0x01..0x08 with `rd_ready_i` = 0. Required response:
  - `wr_ready_o` = 0 after the 8th write;
  - `count_o` = 8, `almost_full_o` = 1 (`AF_THRESH` = 4), `peak_o` = 8;
  - draining reads 0x01..0x08 in order, then `rd_valid_o` = 0, `count_o` = 0, `almost_empty_o` = 1.
- **Full with simultaneous traffic.** When full, hold `wr_valid_i` = 1 and pulse `rd_ready_i` once. Required response: the read completes, the write is refused that cycle, `count_o` = 7, and `wr_ready_o` = 1 the next cycle.
- **Empty write.** Write 0xAA into an empty FIFO with `rd_ready_i` = 1 held. Required response: `rd_valid_o` = 0 in the write cycle, then 1 with `rd_data_o` = 0xAA the next cycle, then empty.
- **Wrap-around streaming.** Stream 100 random words with random valid/ready. Required response: scoreboard order matches, `count_o` always equals the model occupancy, and no data is lost across 12+ pointer wraps.
- **Flush.**
  - Flush with 5 entries stored while `wr_valid_i` = 1. Required response: that write is refused, then `count_o` = 0 and `rd_valid_o` = 0 the next cycle, and `peak_o` is retained at 5.
  - Assert `rst_n` low mid-stream. Required response: all outputs take their reset values immediately.
